// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   N_REQ   : number of requesters (fixed at 4)
//   IDX_W   : width of the encoded grant index
//   state_e : arbiter FSM states
//   pick_t  : result of a rotating-priority search (found flag + index)
//   rr_next : first set bit of req searching from start upward with wrap
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Walk the candidates from the farthest to the nearest so the nearest
  // set bit (relative to start) is the one that sticks.
  function automatic pick_t rr_next(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] start);
    pick_t            r;
    logic [IDX_W-1:0] k;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + IDX_W'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker for 4 requesters.
// Ports:
//   mask_i   : candidate request bits
//   start_i  : index with highest priority; search wraps 3 -> 0
//   onehot_o : one-hot of the selected bit (zero when nothing found)
//   idx_o    : encoded index of the selected bit (zero when nothing found)
//   found_o  : high when any mask bit is set
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  pick_t pick;

  assign pick     = rr_next(mask_i, start_i);
  assign found_o  = pick.found;
  assign idx_o    = pick.idx;
  assign onehot_o = pick.found ? (N_REQ'(1) << pick.idx) : '0;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter sharing one resource between 4 requesters.
// A grant is held while its owner keeps requesting; if others are waiting
// the owner is forcibly rotated out after MAX_HOLD consecutive cycles.
// Ports:
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   req           : level request per requester
//   gnt           : registered one-hot grant, zero when idle
//   gnt_idx       : encoded index of the granted requester, zero when idle
//   gnt_valid     : high while any grant bit is set
//   preempt       : one-cycle pulse when the grant moved due to hold expiry
//   grant_count   : (ARB_STATS_EN) wrapping count of issued grants
//   preempt_count : (ARB_STATS_EN) saturating count of preemptions
// Build option: define ARB_STATS_EN to add the statistics counters.
//
// state | meaning
// IDLE  | no owner, grant outputs zero
// BUSY  | owner = gnt_idx
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      grant_count,
  output logic [7:0]       preempt_count
`endif
);

  if (N_REQ != 4) begin : g_bad_nreq
    $error("rr_arbiter_4 supports exactly 4 requesters");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
  end

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             issue;

  logic [N_REQ-1:0] others;
  logic [IDX_W-1:0] owner_nxt;
  logic [N_REQ-1:0] pick_mask;
  logic [IDX_W-1:0] pick_start;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  assign others    = req & ~gnt_q;
  assign owner_nxt = idx_q + 2'd1;

  // On release the owner bit is already clear, so "others" covers both the
  // release search and the preempt search in BUSY.
  assign pick_mask  = (state_q == BUSY) ? others : req;
  assign pick_start = (state_q == BUSY) ? owner_nxt : rr_ptr_q;

  rr_pick_4 u_pick (
    .mask_i   (pick_mask),
    .start_i  (pick_start),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    preempt_d  = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BUSY;
          gnt_d      = pick_oh;
          idx_d      = pick_idx;
          hold_cnt_d = '0;
          issue      = 1'b1;
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          // Release takes priority over a coincident hold expiry.
          rr_ptr_d   = owner_nxt;
          hold_cnt_d = '0;
          if (pick_found) begin
            gnt_d = pick_oh;
            idx_d = pick_idx;
            issue = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end else if (others != '0 && hold_cnt_q == HOLD_LAST) begin
          gnt_d      = pick_oh;
          idx_d      = pick_idx;
          rr_ptr_d   = owner_nxt;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
          issue      = 1'b1;
        end else if (others != '0) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          // A sole requester never accumulates hold time.
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    valid_d = (gnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt_q;
  logic [7:0]  preempt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_q   <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (issue) begin
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end
      if (preempt_d && preempt_cnt_q != 8'hFF) begin
        preempt_cnt_q <= preempt_cnt_q + 8'd1;
      end
    end
  end

  assign grant_count   = grant_cnt_q;
  assign preempt_count = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD = 8). Inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;
`ifdef ARB_STATS_EN
  logic [15:0] grant_count;
  logic [7:0]  preempt_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
`ifdef ARB_STATS_EN
    ,
    .grant_count   (grant_count),
    .preempt_count (preempt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic p);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    step();
    chk_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef ARB_STATS_EN
    chk("reset.gcnt", 32'(grant_count), 32'd0);
    chk("reset.pcnt", 32'(preempt_count), 32'd0);
`endif

    rst_n = 1'b1;
    step();
    chk_grant("first", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Fairness: each owner drops its request once granted.
    req = 4'b1110; step(); chk_grant("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1101; step(); chk_grant("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1011; step(); chk_grant("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0111; step(); chk_grant("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Preemption: owner 0 holds 8 cycles total, then requester 1 takes over.
    req = 4'b0011;
    for (int i = 1; i < 8; i++) begin
      step();
      chk_grant("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(); chk_grant("pre1", 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_grant("hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step(); chk_grant("pre0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Sole requester: never preempted.
    req = 4'b0100;
    step(); chk_grant("sole.start", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("sole.gnt", 32'(gnt), 32'h4);
      chk("sole.preempt", 32'(preempt), 32'd0);
    end

    // Wrap from owner 3 through idle; rr_ptr wraps to 0.
    req = 4'b1000; step(); chk_grant("to3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000; step(); chk_grant("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0101; step(); chk_grant("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release coinciding with hold expiry: release wins, no preempt pulse.
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pre_rel.hold", 32'(gnt), 32'h1);
    end
    req = 4'b0100; step(); chk_grant("rel_wins", 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef ARB_STATS_EN
    chk("mid.gcnt", 32'(grant_count), 32'd11);
    chk("mid.pcnt", 32'(preempt_count), 32'd2);
`endif

    // Reset while owner 2 holds the grant.
    rst_n = 1'b0; step();
    chk_grant("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef ARB_STATS_EN
    chk("midrst.gcnt", 32'(grant_count), 32'd0);
    chk("midrst.pcnt", 32'(preempt_count), 32'd0);
`endif
    // rr_ptr back at 0 picks requester 0 out of {0,3}.
    rst_n = 1'b1;
    req = 4'b1001; step(); chk_grant("post.g1", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1000; step(); chk_grant("post.g2", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0001; step(); chk_grant("post.g3", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010; step(); chk_grant("post.g4", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0100; step(); chk_grant("post.g5", 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef ARB_STATS_EN
    chk("post.gcnt", 32'(grant_count), 32'd5);
    chk("post.pcnt", 32'(preempt_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4-input resource between 4 requesters.
- Issues a registered one-hot grant plus its 2-bit encoded index, so downstream logic can select the owner without a separate encoder.
- A grant is held while the owner keeps requesting, up to a bounded hold time; it is then forcibly rotated if others are waiting.
- Sits between requester clients and the shared datapath/mux of the combinational-circuits library.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4, elaboration error otherwise.
- IDX_W, 2, width of encoded grant index.
- MAX_HOLD, 8, max consecutive cycles one owner may hold the grant while another request is pending; legal range 2..255.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  4  level request per requester; bit k = requester k.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_idx  output  2  encoded index of set gnt bit; 2'b00 when idle.
- gnt_valid  output  1  high when any gnt bit is set.
- preempt  output  1  one-cycle pulse: the grant just changed owner due to MAX_HOLD expiry.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
  - state=IDLE, hold_cnt=0, rr_ptr=0 (requester 0 has highest priority first).
- States:
  - IDLE: no owner.
  - BUSY: owner = gnt_idx.
- IDLE transitions:
  - If req != 0, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 ... mod 4).
  - Next cycle: gnt = onehot(sel), gnt_idx = sel, gnt_valid = 1, hold_cnt = 0, state = BUSY.
  - Latency from req rise to gnt: 1 cycle.
- BUSY, per cycle:
  - others = req with the owner bit masked.
  - **Release:** req[owner]=0. Pick next from (owner+1) with wrap among req.
    - If a pick exists: switch to it next cycle (back-to-back, no idle gap), hold_cnt=0.
    - Else: gnt=0, state=IDLE.
    - In both cases rr_ptr = owner+1 mod 4.
  - **Preempt:** req[owner]=1, others!=0 and hold_cnt==MAX_HOLD-1.
    - Grant passes to first set bit of others from owner+1.
    - preempt=1 for that one cycle, rr_ptr = owner+1, hold_cnt=0.
  - **Hold:** otherwise grant unchanged.
    - hold_cnt increments while others!=0.
    - hold_cnt is held at 0 while others==0 (a sole requester is never starved and never preempted).
- Grant changes only on clock edges; gnt is never multi-hot; gnt_idx always matches gnt.
- Wrap-around: owner 3 with release → search order 0,1,2,3.
- Simultaneous release and preempt condition: release wins; preempt stays 0.
- Release with owner re-requesting in the same cycle: the owner is last in search order, so it regains the grant only if no one else requests.
- Reset mid-grant: grant drops the cycle after the rst_n=0 edge; rr_ptr returns to 0.
- hold_cnt width is 8 bits and never exceeds MAX_HOLD-1.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output grant_count[15:0], counting every new grant issue (IDLE→BUSY, release switch, preempt switch). Wraps at 16'hFFFF→0; reset to 0.
  - Adds output preempt_count[7:0], saturating at 8'hFF; reset to 0.
- Not defined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ and IDX_W constants.
  - State enum {IDLE, BUSY}.
  - Function rr_next(req, start) returning the 2-bit index and a found flag.
- One sub-module, rr_pick_4: purely combinational rotating-priority picker. Inputs are the 4-bit mask and 2-bit start; outputs are 4-bit one-hot, 2-bit index and found.
- The top instantiates rr_pick_4 once. Its mask/start are muxed by state: req/rr_ptr in IDLE, others-or-req / owner+1 in BUSY.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 → gnt=0, gnt_idx=0, gnt_valid=0. After release, first grant is gnt=4'b0001 one cycle later.
- Fairness rotation: req=4'b1111, each owner drops req for 1 cycle after being granted → grant order 0,1,2,3,0 with no idle cycle between owners.
- Preemption, MAX_HOLD=8: req=4'b0011 held constant → gnt=0001 for 8 cycles. Then gnt=0010 with preempt=1 for 1 cycle; 8 cycles later gnt=0001 again.
- Sole requester: req=4'b0100 for 50 cycles → gnt=0100 throughout, preempt never asserted, gnt_idx=2'b10.
- Wrap and idle: owner 3 releases with req=4'b0000 → gnt=0 next cycle. Then req=4'b0101 → gnt=0001 (rr_ptr=0 after wrap).
- Reset mid-grant, plus ARB_STATS_EN: rst_n=0 while gnt=0100 → outputs 0 and counters 0 next cycle. Five issued grants → grant_count=5.
